harris_corner_stream: RTL and testbench
=======================================

# harris_corner_stream

Parametrised streaming Harris corner detector for the VGA pixel path. Accepts one CH-channel pixel per valid cycle in raster order and converts it to grey. Keeps its own 4-line buffer and position counters. Emits a saturated Harris response R = det(M) − k·trace(M)² with a fixed-latency valid strobe and the centre coordinate. It supersedes the fixed 640-wide, 3-channel, ratio-based detector and adds a valid pipeline, frame sync, a configurable k and an optional threshold flag.

## Interface
Parameters:
- PIX_W, 8, bits per colour channel
- CH, 3, channels per pixel (1..4)
- IMG_W, 640, pixels per line (≥5)
- IMG_H, 480, lines per frame (≥5)
- R_W, 48, response width, signed

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- pix_valid  in  1  pixel present this cycle
- sof  in  1  qualifies the pixel as (0,0); sampled only with pix_valid
- pix_in  in  CH*PIX_W  channels, ch0 in LSBs, unsigned
- k_q8  in  8  k as unsigned Q0.8 (0.04 ≈ 10)
- thresh  in  R_W  signed corner threshold
- resp_valid  out  1  response strobe
- resp  out  R_W  signed Harris response
- resp_x  out  clog2(IMG_W)  centre column
- resp_y  out  clog2(IMG_H)  centre row
- corner  out  1  resp > thresh, qualified by resp_valid

## Operation
- Grey: g = sum of CH channels, unsigned, G_W = PIX_W + clog2(CH) bits (default 10). There is no division.
- Window: 4 line buffers of IMG_W×G_W plus a 5×5 register window. Window and counters advance only on pix_valid.
- Position counters (x,y):
  - sof forces the current pixel to (0,0), including mid-frame.
  - x wraps at IMG_W−1 and increments y.
  - y wraps at IMG_H−1 to 0.
- Emission: a response is produced for an accepted pixel iff x≥4 and y≥4. Its centre is (x−2, y−2). A frame therefore yields (IMG_W−4)(IMG_H−4) responses; border centres are never emitted.
- Gradients: Sobel at each of the 9 inner window positions, all signed with G_W+3 bits.
  - Ix = (right column 1,2,1) − (left column 1,2,1).
  - Iy = (bottom row) − (top row).
- Structure tensor, with uniform weights over 3×3 and full precision:
  - A = ΣIx², C = ΣIy², both ≥0.
  - B = ΣIx·Iy, signed.
- det = A·C − B² and tr = A + C, both full precision signed.
- R = det − ((k_q8·tr²) >>> 8), arithmetic shift, computed full-width. It is then saturated to R_W at ±(2^(R_W−1)−1 / −2^(R_W−1)).
- No truncation anywhere before saturation.

## Timing
- Pipeline, with one register per stage:
  1. window/grey
  2. Sobel
  3. products
  4. 3×3 sums
  5. det, tr²
  6. R and saturation
- Latency: a pixel accepted on edge N gives resp_valid high for exactly one cycle after edge N+6, with resp, resp_x, resp_y and corner valid in that same cycle.
- Throughput: one pixel per clock. Gaps in pix_valid insert bubbles and do not change results. There is no backpressure.
- k_q8 and thresh are sampled in stage 6. They are held stable by the system during a frame.
- Reset:
  - On reset, all of these are 0: resp_valid, resp, resp_x, resp_y, corner, the valid pipeline and the counters.
  - Line-buffer contents are not cleared. This is harmless because emission requires y≥4 after the next (0,0).
  - Reset mid-frame drops all in-flight responses; no resp_valid occurs in the 6 cycles after reset deasserts unless new pixels arrive.
- Pixels arriving after a reset without sof start at (0,0).
- resp and coordinates hold their last value while resp_valid=0.

## Configuration
- HARRIS_THRESH_EN defined: corner = resp_valid && (resp > thresh), signed compare, registered with resp.
- Not defined: corner tied to 0, thresh unused, no comparator synthesised.
- No other behaviour changes.

## Test plan
- Constant image, IMG_W=16, IMG_H=8, pix_in=0x404040, k_q8=10: expect exactly 48 resp_valid pulses, all resp=0. The first pulse comes 6 cycles after pixel (4,4) with resp_x=2, resp_y=2; the last has (13,5).
- Vertical step edge (columns <8 =0, ≥8 =255 per channel), k_q8=0: every resp=0 because C=B=0. With k_q8=10, resp<0 at columns 6..9 and 0 elsewhere.
- Single bright 3×3 square on a black field, k_q8=10, thresh=0, HARRIS_THRESH_EN: resp>0 and corner=1 at the square's corner centres; corner=0 on flat regions.
- Same frame as the constant-image test with pix_valid randomly low 50% of cycles: the response sequence and coordinates are identical to the gap-free run.
- Reset asserted for one cycle at pixel (9,5): no resp_valid afterwards until y≥4 of the next frame. All outputs read 0 the cycle after reset.
- sof at pixel index 30 of a frame: counters restart, and the next emitted centre is (2,2) after a further 4 full lines plus 5 pixels.

Source files
------------

// File: rtl/harris_corner_stream.sv
`default_nettype none
// ============================================================================
// Module   : harris_corner_stream
// Brief    : Streaming Harris corner response with grey conversion, 4-line
//            buffer, 5x5 window and a fixed-latency result strobe.
//            Optional macro HARRIS_THRESH_EN enables the corner flag.
// Revision : 1.0
// ============================================================================
module harris_corner_stream #(
    parameter int PIX_W = 8,
    parameter int CH    = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int R_W   = 48
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_valid,
    input  logic                      sof,
    input  logic [CH*PIX_W-1:0]       pix_in,
    input  logic [7:0]                k_q8,
    input  logic signed [R_W-1:0]     thresh,
    output logic                      resp_valid,
    output logic signed [R_W-1:0]     resp,
    output logic [$clog2(IMG_W)-1:0]  resp_x,
    output logic [$clog2(IMG_H)-1:0]  resp_y,
    output logic                      corner
);
    localparam int c_G_W  = PIX_W + $clog2(CH);
    localparam int c_SB_W = c_G_W + 3;
    localparam int c_P_W  = 2 * c_SB_W;
    localparam int c_S_W  = c_P_W + 4;
    localparam int c_F_W0 = 2 * c_S_W + 12;
    localparam int c_F_W  = (c_F_W0 > R_W + 1) ? c_F_W0 : R_W + 1;
    localparam int c_X_W  = $clog2(IMG_W);
    localparam int c_Y_W  = $clog2(IMG_H);
    localparam int c_NSTG = 6;
    localparam logic signed [c_F_W-1:0] c_R_MAX = {{(c_F_W-R_W+1){1'b0}}, {(R_W-1){1'b1}}};
    localparam logic signed [c_F_W-1:0] c_R_MIN = {{(c_F_W-R_W+1){1'b1}}, {(R_W-1){1'b0}}};

    logic [c_G_W-1:0] w_grey;
    always_comb begin
        w_grey = '0;
        for (int i = 0; i < CH; i++)
            w_grey = w_grey + c_G_W'(pix_in[i*PIX_W +: PIX_W]);
    end

    // r_nx/r_ny hold the position of the next expected pixel; sof overrides it.
    logic [c_X_W-1:0] r_nx, w_cx;
    logic [c_Y_W-1:0] r_ny, w_cy;
    logic             w_emit;
    assign w_cx   = sof ? '0 : r_nx;
    assign w_cy   = sof ? '0 : r_ny;
    assign w_emit = pix_valid && (w_cx >= c_X_W'(4)) && (w_cy >= c_Y_W'(4));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nx <= '0;
            r_ny <= '0;
        end else if (pix_valid) begin
            if (w_cx == c_X_W'(IMG_W - 1)) begin
                r_nx <= '0;
                r_ny <= (w_cy == c_Y_W'(IMG_H - 1)) ? '0 : w_cy + c_Y_W'(1);
            end else begin
                r_nx <= w_cx + c_X_W'(1);
                r_ny <= w_cy;
            end
        end
    end

    // Read-before-write line buffers; r_col[0] is the oldest row (y-4).
    logic [c_G_W-1:0] r_lb  [4][IMG_W];
    logic [c_G_W-1:0] r_col [5];
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb[0][w_cx] <= w_grey;
            for (int i = 1; i < 4; i++)
                r_lb[i][w_cx] <= r_lb[i-1][w_cx];
            for (int i = 0; i < 4; i++)
                r_col[i] <= r_lb[3-i][w_cx];
            r_col[4] <= w_grey;
        end
    end

    logic                    r_shift;
    logic [c_NSTG-1:0]       r_v;
    logic [c_X_W-1:0]        r_px [c_NSTG];
    logic [c_Y_W-1:0]        r_py [c_NSTG];
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= 1'b0;
            r_v     <= '0;
        end else begin
            r_shift <= pix_valid;
            r_v     <= {r_v[c_NSTG-2:0], w_emit};
        end
    end

    always_ff @(posedge clk) begin
        r_px[0] <= w_cx - c_X_W'(2);
        r_py[0] <= w_cy - c_Y_W'(2);
        for (int i = 1; i < c_NSTG; i++) begin
            r_px[i] <= r_px[i-1];
            r_py[i] <= r_py[i-1];
        end
    end

    logic [c_G_W-1:0] r_win [5][5];
    always_ff @(posedge clk) begin
        if (r_shift) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++)
                    r_win[r][c] <= r_win[r][c+1];
                r_win[r][4] <= r_col[r];
            end
        end
    end

    function automatic logic signed [c_SB_W-1:0] f_ext(input logic [c_G_W-1:0] v);
        return $signed({3'b000, v});
    endfunction

    logic signed [c_SB_W-1:0] r_ix [9];
    logic signed [c_SB_W-1:0] r_iy [9];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r_ix[3*i+j] <= (f_ext(r_win[i][j+2]) + (f_ext(r_win[i+1][j+2]) <<< 1) + f_ext(r_win[i+2][j+2]))
                             - (f_ext(r_win[i][j])   + (f_ext(r_win[i+1][j])   <<< 1) + f_ext(r_win[i+2][j]));
                r_iy[3*i+j] <= (f_ext(r_win[i+2][j]) + (f_ext(r_win[i+2][j+1]) <<< 1) + f_ext(r_win[i+2][j+2]))
                             - (f_ext(r_win[i][j])   + (f_ext(r_win[i][j+1])   <<< 1) + f_ext(r_win[i][j+2]));
            end
        end
    end

    logic signed [c_P_W-1:0] r_pxx [9];
    logic signed [c_P_W-1:0] r_pyy [9];
    logic signed [c_P_W-1:0] r_pxy [9];
    always_ff @(posedge clk) begin
        for (int n = 0; n < 9; n++) begin
            r_pxx[n] <= c_P_W'(r_ix[n]) * c_P_W'(r_ix[n]);
            r_pyy[n] <= c_P_W'(r_iy[n]) * c_P_W'(r_iy[n]);
            r_pxy[n] <= c_P_W'(r_ix[n]) * c_P_W'(r_iy[n]);
        end
    end

    logic signed [c_S_W-1:0] w_sa, w_sb, w_sc;
    logic signed [c_S_W-1:0] r_a, r_b, r_c;
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        w_sc = '0;
        for (int n = 0; n < 9; n++) begin
            w_sa = w_sa + c_S_W'(r_pxx[n]);
            w_sb = w_sb + c_S_W'(r_pxy[n]);
            w_sc = w_sc + c_S_W'(r_pyy[n]);
        end
    end

    logic signed [c_F_W-1:0] r_det, r_tr2;
    always_ff @(posedge clk) begin
        r_a   <= w_sa;
        r_b   <= w_sb;
        r_c   <= w_sc;
        r_det <= c_F_W'(r_a) * c_F_W'(r_c) - c_F_W'(r_b) * c_F_W'(r_b);
        r_tr2 <= (c_F_W'(r_a) + c_F_W'(r_c)) * (c_F_W'(r_a) + c_F_W'(r_c));
    end

    logic signed [c_F_W-1:0] w_kt, w_r;
    logic signed [R_W-1:0]   w_sat;
    always_comb begin
        w_kt = c_F_W'($signed({1'b0, k_q8})) * r_tr2;
        w_r  = r_det - (w_kt >>> 8);
        if (w_r > c_R_MAX)
            w_sat = {1'b0, {(R_W-1){1'b1}}};
        else if (w_r < c_R_MIN)
            w_sat = {1'b1, {(R_W-1){1'b0}}};
        else
            w_sat = w_r[R_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp       <= '0;
            resp_x     <= '0;
            resp_y     <= '0;
        end else begin
            resp_valid <= r_v[c_NSTG-1];
            if (r_v[c_NSTG-1]) begin
                resp   <= w_sat;
                resp_x <= r_px[c_NSTG-1];
                resp_y <= r_py[c_NSTG-1];
            end
        end
    end

`ifdef HARRIS_THRESH_EN
    logic r_corner;
    always_ff @(posedge clk) begin
        if (reset)
            r_corner <= 1'b0;
        else
            r_corner <= r_v[c_NSTG-1] && (w_sat > thresh);
    end
    assign corner = r_corner;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^thresh;
    assign corner          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_harris_corner_stream.sv
`default_nettype none
// tb_harris_corner_stream : table-driven frames plus reset/sof sequences on a
// 16x8 image, checked against a direct Harris model through a scoreboard.
module tb_harris_corner_stream;
    localparam int PIX_W = 8;
    localparam int CH    = 3;
    localparam int IMG_W = 16;
    localparam int IMG_H = 8;
    localparam int R_W   = 48;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pix_valid;
    logic                  sof;
    logic [CH*PIX_W-1:0]   pix_in;
    logic [7:0]            k_q8;
    logic signed [R_W-1:0] thresh;
    logic                  resp_valid;
    logic signed [R_W-1:0] resp;
    logic [3:0]            resp_x;
    logic [2:0]            resp_y;
    logic                  corner;

    always #5 clk = ~clk;

    harris_corner_stream #(
        .PIX_W(PIX_W), .CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H), .R_W(R_W)
    ) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .sof(sof),
        .pix_in(pix_in), .k_q8(k_q8), .thresh(thresh),
        .resp_valid(resp_valid), .resp(resp), .resp_x(resp_x),
        .resp_y(resp_y), .corner(corner)
    );

    typedef struct {
        logic signed [R_W-1:0] r;
        int                    x;
        int                    y;
        bit                    c;
        longint                cyc;
    } exp_t;

    typedef struct {
        int     pat;
        int     k;
        longint thr;
        int     gap;
        int     pulses;
    } case_t;

    exp_t                  sb[$];
    int                    total = 0;
    int                    bad = 0;
    int                    n_pulse = 0;
    longint                cyc = 0;
    longint                first_cyc = 0;
    int                    first_x = 0;
    int                    first_y = 0;
    logic signed [R_W-1:0] last_r = '0;
    int                    last_x = 0;
    int                    last_y = 0;
    int                    gimg [IMG_H][IMG_W];
    int                    bx = 0;
    int                    by = 0;
    int                    cur_pat = 0;
    int                    cur_k = 0;
    logic signed [R_W-1:0] cur_thr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Direct Harris response at centre (cx,cy) from the grey image.
    function automatic logic signed [R_W-1:0] ref_resp(input int cx, input int cy, input int k);
        longint a = 0, b = 0, c = 0;
        int ix, iy;
        logic signed [127:0] sa, sb2, sc, det, tr2, r, mx, mn;
        for (int y = cy - 1; y <= cy + 1; y++) begin
            for (int x = cx - 1; x <= cx + 1; x++) begin
                ix = (gimg[y-1][x+1] + 2*gimg[y][x+1] + gimg[y+1][x+1])
                   - (gimg[y-1][x-1] + 2*gimg[y][x-1] + gimg[y+1][x-1]);
                iy = (gimg[y+1][x-1] + 2*gimg[y+1][x] + gimg[y+1][x+1])
                   - (gimg[y-1][x-1] + 2*gimg[y-1][x] + gimg[y-1][x+1]);
                a += longint'(ix) * longint'(ix);
                c += longint'(iy) * longint'(iy);
                b += longint'(ix) * longint'(iy);
            end
        end
        sa  = a;
        sb2 = b;
        sc  = c;
        det = sa * sc - sb2 * sb2;
        tr2 = (sa + sc) * (sa + sc);
        r   = det - ((tr2 * k) >>> 8);
        mx  = (128'sd1 <<< (R_W - 1)) - 128'sd1;
        mn  = -mx - 128'sd1;
        if (r > mx) r = mx;
        if (r < mn) r = mn;
        return r[R_W-1:0];
    endfunction

    function automatic logic [23:0] pat_pix(input int pat, input int x, input int y);
        logic [7:0] v;
        case (pat)
            0: v = 8'h40;
            1: v = (x >= 8) ? 8'hFF : 8'h00;
            2: v = (x >= 6 && x <= 8 && y >= 2 && y <= 4) ? 8'hFF : 8'h00;
            3: return 24'($urandom);
            default: v = ((((x >> 1) + (y >> 1)) & 1) != 0) ? 8'hFF : 8'h00;
        endcase
        return {v, v, v};
    endfunction

    task automatic drive_px(input bit s, input int gap);
        logic [23:0] p;
        exp_t e;
        while ($urandom_range(0, 99) < gap) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'($urandom_range(0, 1));
            pix_in    = 24'($urandom);
        end
        @(negedge clk);
        if (s) begin
            bx = 0;
            by = 0;
        end
        p         = pat_pix(cur_pat, bx, by);
        pix_valid = 1'b1;
        sof       = s;
        pix_in    = p;
        gimg[by][bx] = int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16]);
        if (bx >= 4 && by >= 4) begin
            e.r = ref_resp(bx - 2, by - 2, cur_k);
            e.x = bx - 2;
            e.y = by - 2;
`ifdef HARRIS_THRESH_EN
            e.c = (e.r > cur_thr);
`else
            e.c = 1'b0;
`endif
            e.cyc = cyc + 7;
            sb.push_back(e);
        end
        if (bx == IMG_W - 1) begin
            bx = 0;
            by = (by == IMG_H - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            pix_valid = 1'b0;
            t++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        idle(3);
        chk("hold_valid", 64'(resp_valid), 0);
        chk("hold_resp", resp, last_r);
        chk("hold_x", 64'(resp_x), last_x);
        chk("hold_y", 64'(resp_y), last_y);
    endtask

    task automatic check_zero_outputs();
        chk("rst_valid", 64'(resp_valid), 0);
        chk("rst_resp", resp, 0);
        chk("rst_x", 64'(resp_x), 0);
        chk("rst_y", 64'(resp_y), 0);
        chk("rst_corner", 64'(corner), 0);
    endtask

    task automatic set_case(input int pat, input int k, input longint thr);
        cur_pat = pat;
        cur_k   = k;
        k_q8    = 8'(k);
        thresh  = R_W'(thr);
        cur_thr = R_W'(thr);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (n_pulse == 0) begin
                first_cyc = cyc;
                first_x   = int'(resp_x);
                first_y   = int'(resp_y);
            end
            n_pulse++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_valid: got pulse at (%0d,%0d), required none", resp_x, resp_y);
            end else begin
                e = sb.pop_front();
                chk("resp", resp, e.r);
                chk("resp_x", 64'(resp_x), e.x);
                chk("resp_y", 64'(resp_y), e.y);
                chk("corner", 64'(corner), 64'(e.c));
                chk("latency", cyc, e.cyc);
                last_r = e.r;
                last_x = e.x;
                last_y = e.y;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        case_t  tbl[8];
        longint s_cyc;
        tbl[0] = '{0, 10,      0,  0, 48};
        tbl[1] = '{1,  0,      0,  0, 48};
        tbl[2] = '{1, 10,      0,  0, 48};
        tbl[3] = '{2, 10,      0,  0, 48};
        tbl[4] = '{0, 10,      0, 50, 48};
        tbl[5] = '{3, 10, 100000, 30, 48};
        tbl[6] = '{4, 255,    -5,  0, 48};
        tbl[7] = '{4,  0,      0, 20, 48};

        reset = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0; k_q8 = '0; thresh = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_zero_outputs();

        for (int i = 0; i < 8; i++) begin
            set_case(tbl[i].pat, tbl[i].k, tbl[i].thr);
            n_pulse = 0;
            for (int p = 0; p < IMG_W * IMG_H; p++)
                drive_px(p == 0, tbl[i].gap);
            idle(1);
            drain();
            chk("pulse_count", n_pulse, tbl[i].pulses);
        end

        // Reset in place of pixel (9,5): in-flight results vanish.
        set_case(3, 10, 0);
        drive_px(1'b1, 0);
        while (!(bx == 9 && by == 5)) drive_px(1'b0, 0);
        @(negedge clk);
        pix_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero_outputs();
        sb.delete();
        bx = 0;
        by = 0;
        n_pulse = 0;
        repeat (IMG_W * IMG_H - (5 * IMG_W + 9)) drive_px(1'b0, 0);
        idle(10);
        chk("post_reset_pulses", n_pulse, 0);
        n_pulse = 0;
        for (int p = 0; p < IMG_W * IMG_H; p++) drive_px(p == 0, 0);
        idle(1);
        drain();
        chk("post_reset_frame", n_pulse, 48);

        // sof at pixel index 30: first centre (2,2) follows 4 lines + 5 pixels later.
        set_case(3, 10, 0);
        n_pulse = 0;
        drive_px(1'b1, 0);
        repeat (29) drive_px(1'b0, 0);
        drive_px(1'b1, 0);
        s_cyc = cyc;
        repeat (IMG_W * IMG_H - 1) drive_px(1'b0, 0);
        idle(1);
        drain();
        chk("sof_first_cyc", first_cyc, s_cyc + 4 * IMG_W + 4 + 7);
        chk("sof_first_x", first_x, 2);
        chk("sof_first_y", first_y, 2);
        chk("sof_pulses", n_pulse, 48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
